fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage directly upstream of the controller. Holds the PC, issues
//   one-outstanding fetches to instruction memory over a req/gnt/rvalid handshake,
//   latches the returned word and presents Instr plus decoded op/funct3/funct7 fields.
//   The PC advances only when execute retires the instruction, using the
//   PCSrc/PCTarget pair that execute produces.
// PARAMETERS
//   XLEN      32            PC/address width
//   RESET_PC  32'h0000_0000 PC loaded on reset; must be word aligned
// PORTS
//   clk          in   1     rising-edge clock
//   reset        in   1     synchronous, active-high reset
//   imem_req     out  1     fetch request; held until imem_gnt
//   imem_addr    out  XLEN  fetch address (= PC); stable while imem_req=1
//   imem_gnt     in   1     memory accepts request this cycle
//   imem_rvalid  in   1     imem_rdata valid this cycle
//   imem_rdata   in   32    fetched instruction word
//   retire       in   1     execute consumed current Instr this cycle
//   PCSrc        in   1     1: next PC = PCTarget, 0: next PC = PC+4 (sampled on retire)
//   PCTarget     in   XLEN  branch/jump target
//   instr_valid  out  1     Instr/op/funct3/funct7 hold a valid fetched word
//   Instr        out  32    latched instruction
//   op           out  7     Instr[6:0]
//   funct3       out  3     Instr[14:12]
//   funct7       out  7     Instr[31:25]
//   PC           out  XLEN  address of Instr
//   PCPlus4      out  XLEN  PC + 4, modulo 2^XLEN
//   fault        out  1     sticky: misaligned redirect target
// BEHAVIOUR
//   Reset (sync, active-high, overrides all inputs): PC=RESET_PC, Instr=32'h0000_0013
//     (NOP), instr_valid=0, imem_req=0, fault=0, state=FETCH. Takes effect at the clock
//     edge on which reset=1 is sampled.
//   FSM states: FETCH, WAIT, HOLD, FAULT.
//     FETCH: imem_req=1, imem_addr=PC. On imem_gnt -> WAIT; else stay.
//     WAIT : imem_req=0. On imem_rvalid: Instr<=imem_rdata, instr_valid<=1 -> HOLD.
//     HOLD : instr_valid=1, outputs stable. On retire:
//            next=PCSrc?PCTarget:PCPlus4. If next[1:0]!=0 -> FAULT (fault<=1, PC unchanged);
//            else PC<=next, instr_valid<=0 -> FETCH.
//     FAULT: instr_valid=0, imem_req=0, fault=1; leaves only via reset.
//   Latency: gnt on cycle N, rvalid on N+k (k>=1) -> instr_valid=1 from N+k+1.
//     Minimum retire-to-retire interval with gnt immediate and k=1: 3 cycles.
//   imem_rvalid outside WAIT is ignored, including a stale response arriving after reset
//     while in FETCH. imem_gnt outside FETCH is ignored.
//   retire outside HOLD is ignored; PCSrc/PCTarget matter only on a retire in HOLD.
//   PC+4 wraps modulo 2^XLEN (PC=32'hFFFF_FFFC -> PCPlus4=0); wrap is not a fault.
//   Decoded fields are combinational slices of the registered Instr; they show the NOP
//     fields (op=7'h13) whenever instr_valid=0 after reset.
//   Reset mid-transaction (WAIT or HOLD): the outstanding fetch is abandoned and the
//     first post-reset request is to RESET_PC.
// TESTING
//   Reset, gnt same cycle, rvalid next cycle with rdata=32'h00500093 -> imem_addr=0,
//     instr_valid=1 two cycles after gnt, op=7'h13, funct3=0, PC=0.
//   Retire with PCSrc=0 at PC=0x10 -> next imem_addr=0x14; PCPlus4 was 0x14 during HOLD.
//   Retire with PCSrc=1, PCTarget=0x40 -> next imem_addr=0x40, instr_valid drops for one
//     or more cycles.
//   Retire with PCSrc=1, PCTarget=0x42 -> fault=1, instr_valid=0, imem_req stays 0 until
//     reset.
//   Gnt delayed 3 cycles -> imem_req/imem_addr held stable 4 cycles; stray rvalid during
//     FETCH ignored.
//   Reset asserted in WAIT, old rvalid arrives next cycle -> ignored; fetch reissued at
//     RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the PC and issues one fetch at a
//            time over a req/gnt/rvalid handshake. It latches the returned word
//            and presents Instr together with the decoded op/funct3/funct7.
//            The PC advances only when execute retires the current
//            instruction, using PCSrc/PCTarget.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            imem_req/imem_addr       - fetch request and address (= PC)
//            imem_gnt                 - memory accepted the request
//            imem_rvalid/imem_rdata   - returned instruction word
//            retire, PCSrc, PCTarget  - retire strobe and next-PC selection
//            instr_valid, Instr, op,
//            funct3, funct7           - latched instruction and decoded fields
//            PC, PCPlus4              - address of Instr, and that address + 4
//            fault                    - sticky misaligned-redirect flag
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            retire,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            instr_valid,
  output logic [31:0]     Instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            fault
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  // Plain modular add: PC wrap-around at the top of the address space is legal.
  assign pc_plus4 = pc_q + XLEN'(4);
  assign next_pc  = PCSrc ? PCTarget : pc_plus4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          // A misaligned target freezes the PC on the offending instruction.
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= C_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // The request is masked while reset is held, so nothing is issued before the
  // fetch state is established.
  assign imem_req    = (state_q == S_FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign fault       = (state_q == S_FAULT);
  assign Instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural memory responds
//            with random grant/response latencies. A reference model tracks
//            the expected PC and fault state from the retire rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            retire;
  logic            PCSrc;
  logic [XLEN-1:0] PCTarget;
  logic            instr_valid;
  logic [31:0]     Instr;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic            fault;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .retire     (retire),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .instr_valid(instr_valid),
    .Instr      (Instr),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] exp_pc;
  bit          exp_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: an arbitrary address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3A5;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_req",   imem_req,    0);
    check_eq("rst_fault", fault,       0);
    check_eq("rst_pc",    PC,          RESET_PC);
    check_eq("rst_instr", Instr,       NOP);
    check_eq("rst_op",    op,          32'h13);
    reset = 1'b0;
    @(negedge clk);
    exp_pc = RESET_PC; exp_fault = 1'b0;
  endtask

  // One complete fetch. On entry the DUT is expected to be requesting.
  task automatic do_fetch(input logic [31:0] w, input int d, input int k, input bit stray);
    check_eq("f_req",   imem_req,    1);
    check_eq("f_addr",  imem_addr,   exp_pc);
    check_eq("f_valid", instr_valid, 0);
    for (int i = 0; i < d; i++) begin
      imem_gnt = 1'b0; imem_rvalid = stray; imem_rdata = $urandom;
      @(negedge clk);
      check_eq("f_req_hold",  imem_req,    1);
      check_eq("f_addr_hold", imem_addr,   exp_pc);
      check_eq("f_stray",     instr_valid, 0);
    end
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check_eq("w_req",   imem_req,    0);
    check_eq("w_valid", instr_valid, 0);
    for (int i = 1; i < k; i++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("w_req",   imem_req,    0);
      check_eq("w_valid", instr_valid, 0);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    check_eq("h_valid",  instr_valid, 1);
    check_eq("h_instr",  Instr,       w);
    check_eq("h_op",     op,          {25'd0, w[6:0]});
    check_eq("h_funct3", funct3,      {29'd0, w[14:12]});
    check_eq("h_funct7", funct7,      {25'd0, w[31:25]});
    check_eq("h_pc",     PC,          exp_pc);
    check_eq("h_pc4",    PCPlus4,     exp_pc + 32'd4);
  endtask

  // Idle for 'pre' cycles in HOLD, then retire once and update the model.
  task automatic do_retire(input bit src, input logic [31:0] tgt, input int pre);
    logic [31:0] nxt;
    logic [31:0] held;
    held = Instr;
    for (int i = 0; i < pre; i++) begin
      retire = 1'b0; PCSrc = 1'($urandom); PCTarget = $urandom;
      imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom);
      @(negedge clk);
      check_eq("hold_valid", instr_valid, 1);
      check_eq("hold_instr", Instr,       held);
      check_eq("hold_req",   imem_req,    0);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    retire = 1'b1; PCSrc = src; PCTarget = tgt;
    @(negedge clk);
    retire = 1'b0; PCSrc = 1'($urandom); PCTarget = $urandom;
    nxt = src ? tgt : exp_pc + 32'd4;
    if (nxt % 4 != 0) exp_fault = 1'b1;
    else              exp_pc    = nxt;
    check_eq("r_fault", fault,       exp_fault);
    check_eq("r_valid", instr_valid, 0);
    check_eq("r_pc",    PC,          exp_pc);
    check_eq("r_req",   imem_req,    exp_fault ? 0 : 1);
  endtask

  // Confirm the sticky fault holds despite arbitrary input activity.
  task automatic check_fault_sticky(input int n);
    for (int i = 0; i < n; i++) begin
      imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom); retire = 1'($urandom);
      PCSrc = 1'($urandom); PCTarget = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      check_eq("flt_fault", fault,       1);
      check_eq("flt_valid", instr_valid, 0);
      check_eq("flt_req",   imem_req,    0);
      check_eq("flt_pc",    PC,          exp_pc);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    bit          src;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    retire = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    exp_pc = RESET_PC; exp_fault = 1'b0;

    // Directed opening sequence
    do_reset();
    do_fetch(32'h0050_0093, 0, 1, 1'b0);
    check_eq("first_op", op, 32'h13);
    do_retire(1'b1, 32'h10, 0);
    do_fetch(mem_word(exp_pc), 0, 1, 1'b0);
    check_eq("pc4_at_10", PCPlus4, 32'h14);
    do_retire(1'b0, 32'hDEAD_BEEF, 1);
    check_eq("addr_14", imem_addr, 32'h14);
    do_fetch(mem_word(exp_pc), 0, 2, 1'b0);
    do_retire(1'b1, 32'h40, 0);
    check_eq("addr_40", imem_addr, 32'h40);
    do_fetch(mem_word(exp_pc), 3, 1, 1'b1);
    do_retire(1'b1, 32'hFFFF_FFFC, 0);
    do_fetch(mem_word(exp_pc), 1, 1, 1'b0);
    check_eq("wrap_pc4", PCPlus4, 32'h0);
    do_retire(1'b0, 32'h0, 0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset while WAIT, stale response arrives on the first post-reset cycle
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_rvalid = 1'b0;
    exp_pc = RESET_PC;
    check_eq("stale_valid", instr_valid, 0);
    check_eq("stale_req",   imem_req,    1);
    check_eq("stale_addr",  imem_addr,   RESET_PC);
    do_fetch(mem_word(exp_pc), 0, 1, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      src = 1'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) begin
        src = 1'b1;
        tgt[1:0] = 2'($urandom_range(1, 3));
      end
      do_retire(src, tgt, $urandom_range(0, 2));
      if (exp_fault) begin
        check_fault_sticky(3);
        do_reset();
      end
      do_fetch(mem_word(exp_pc), $urandom_range(0, 3), $urandom_range(1, 3),
               1'($urandom));
    end

    // Directed misaligned redirect
    do_retire(1'b1, 32'h42, 0);
    check_eq("flt_42", fault, 1);
    check_fault_sticky(4);
    do_reset();
    do_fetch(mem_word(exp_pc), 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
